// File: rtl/matmul_pkg.sv
// Shared state encodings and sizing helpers for the matrix-multiply scheduler.
package matmul_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t LOAD_B = 3'd1;
  localparam state_t LOAD_A = 3'd2;
  localparam state_t MAC    = 3'd3;
  localparam state_t EMIT   = 3'd4;
  localparam state_t DONE   = 3'd5;

  localparam int P_MAX_N = 4;

  // Counter width that never collapses to zero bits for tiny sizes.
  function automatic int cw(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  localparam int CNT_W  = cw(P_MAX_N);
  localparam int ADDR_W = cw(P_MAX_N * P_MAX_N);

endpackage

// File: rtl/matmul_mac.sv
// Registered multiply-accumulate with synchronous clear and enable; wraps modulo 2^W.
module matmul_mac
  import matmul_pkg::*;
#(
  parameter int pDATA_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   en,
  input  logic [pDATA_WIDTH-1:0] a,
  input  logic [pDATA_WIDTH-1:0] b,
  output logic [pDATA_WIDTH-1:0] acc
);

  // Accumulator: clear wins over enable so a new dot product starts at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + a * b;
    end
  end

endmodule

// File: rtl/matmul_sched.sv
// matmul_sched: buffers B and one A row, then runs one MAC over the row x column schedule.
// Optional build macro MATMUL_SCHED_TLAST_CHECK_EN adds the sticky err_tlast framing monitor.
module matmul_sched
  import matmul_pkg::*;
#(
  parameter int pDATA_WIDTH = 32,
  parameter int pMAX_N      = P_MAX_N,
  parameter int pN_WIDTH    = 3
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   ap_start,
  input  logic [pN_WIDTH-1:0]    ap_n,
  output logic                   ap_busy,
  output logic                   ap_done,
  input  logic                   ss_tvalid_A,
  input  logic [pDATA_WIDTH-1:0] ss_tdata_A,
  input  logic                   ss_tlast_A,
  output logic                   ss_tready_A,
  input  logic                   ss_tvalid_B,
  input  logic [pDATA_WIDTH-1:0] ss_tdata_B,
  input  logic                   ss_tlast_B,
  output logic                   ss_tready_B,
  input  logic                   sm_tready,
  output logic                   sm_tvalid,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
`ifdef MATMUL_SCHED_TLAST_CHECK_EN
  output logic                   sm_tlast,
  output logic                   err_tlast
`else
  output logic                   sm_tlast
`endif
);

  localparam int KW    = cw(pMAX_N);
  localparam int AW    = cw(pMAX_N * pMAX_N);
  localparam int DEPTH = pMAX_N * pMAX_N;

  state_t                  state, state_nxt;
  logic [pN_WIDTH-1:0]     n;
  logic [AW-1:0]           cnt, nn_last, n_last_a, b_idx;
  logic [KW-1:0]           i, j, k, n_last_k;
  logic                    hs_a, hs_b, hs_c, start_ok;
  logic                    last_a, last_b, last_i, last_j, last_k;
  logic                    mac_clr, mac_en;
  logic [pDATA_WIDTH-1:0]  acc, mac_a, mac_b;
  logic [pDATA_WIDTH-1:0]  abuf [pMAX_N];
  logic [pDATA_WIDTH-1:0]  bbuf [DEPTH];

  assign hs_a     = ss_tvalid_A & ss_tready_A;
  assign hs_b     = ss_tvalid_B & ss_tready_B;
  assign hs_c     = sm_tvalid & sm_tready;
  assign start_ok = ap_start && (ap_n != pN_WIDTH'(0)) && (ap_n <= pN_WIDTH'(pMAX_N));
  assign n_last_a = AW'(n) - AW'(1'b1);
  assign n_last_k = KW'(n - pN_WIDTH'(1'b1));
  assign last_b   = (cnt == nn_last);
  assign last_a   = (cnt == n_last_a);
  assign last_i   = (i == n_last_k);
  assign last_j   = (j == n_last_k);
  assign last_k   = (k == n_last_k);
  assign b_idx    = AW'(k) * AW'(n) + AW'(j);
  assign mac_a    = abuf[k];
  assign mac_b    = bbuf[b_idx];

`ifndef MATMUL_SCHED_TLAST_CHECK_EN
  logic tlast_unused;
  assign tlast_unused = ss_tlast_A ^ ss_tlast_B;
`endif

  // Next-state decode; the MAC is cleared on every entry into MAC.
  always_comb begin
    state_nxt = state;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) state_nxt = LOAD_B;
        else          state_nxt = IDLE;
      end
      LOAD_B: begin
        if (hs_b && last_b) state_nxt = LOAD_A;
        else                state_nxt = LOAD_B;
      end
      LOAD_A: begin
        if (hs_a && last_a) begin
          state_nxt = MAC;
          mac_clr   = 1'b1;
        end else begin
          state_nxt = LOAD_A;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (last_k) state_nxt = EMIT;
        else        state_nxt = MAC;
      end
      EMIT: begin
        if (hs_c) begin
          if (!last_j) begin
            state_nxt = MAC;
            mac_clr   = 1'b1;
          end else if (!last_i) begin
            state_nxt = LOAD_A;
          end else begin
            state_nxt = DONE;
          end
        end else begin
          state_nxt = EMIT;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters and registered outputs; readies decode the next state.
  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      state       <= IDLE;
      n           <= '0;
      nn_last     <= '0;
      cnt         <= '0;
      i           <= '0;
      j           <= '0;
      k           <= '0;
      ap_busy     <= 1'b0;
      ap_done     <= 1'b0;
      ss_tready_A <= 1'b0;
      ss_tready_B <= 1'b0;
      sm_tvalid   <= 1'b0;
      sm_tdata    <= '0;
      sm_tlast    <= 1'b0;
    end else begin
      state       <= state_nxt;
      ap_busy     <= (state_nxt != IDLE);
      ap_done     <= (state == DONE);
      ss_tready_A <= (state_nxt == LOAD_A);
      ss_tready_B <= (state_nxt == LOAD_B);
      case (state)
        IDLE: begin
          if (start_ok) begin
            n       <= ap_n;
            nn_last <= AW'(ap_n) * AW'(ap_n) - AW'(1'b1);
            cnt     <= '0;
            i       <= '0;
            j       <= '0;
            k       <= '0;
          end
        end
        LOAD_B: begin
          if (hs_b) cnt <= last_b ? '0 : cnt + AW'(1'b1);
        end
        LOAD_A: begin
          if (hs_a) begin
            cnt <= last_a ? '0 : cnt + AW'(1'b1);
            j   <= '0;
            k   <= '0;
          end
        end
        MAC: k <= last_k ? '0 : k + KW'(1'b1);
        EMIT: begin
          if (!sm_tvalid) begin
            sm_tvalid <= 1'b1;
            sm_tdata  <= acc;
            sm_tlast  <= last_i && last_j;
          end else if (sm_tready) begin
            sm_tvalid <= 1'b0;
            sm_tlast  <= 1'b0;
            if (!last_j) begin
              j <= j + KW'(1'b1);
              k <= '0;
            end else if (!last_i) begin
              i   <= i + KW'(1'b1);
              j   <= '0;
              cnt <= '0;
            end else begin
              i <= '0;
              j <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Operand buffers are plain storage and deliberately not reset.
  always_ff @(posedge axis_clk) begin
    if (hs_b) bbuf[cnt] <= ss_tdata_B;
    if (hs_a) abuf[cnt[KW-1:0]] <= ss_tdata_A;
  end

`ifdef MATMUL_SCHED_TLAST_CHECK_EN
  // Sticky framing error: early B tlast, or A tlast not exactly on the final A word.
  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      err_tlast <= 1'b0;
    end else if (state == IDLE && start_ok) begin
      err_tlast <= 1'b0;
    end else if ((hs_b && ss_tlast_B && !last_b) ||
                 (hs_a && (ss_tlast_A != (last_i && last_a)))) begin
      err_tlast <= 1'b1;
    end
  end
`endif

  matmul_mac #(.pDATA_WIDTH(pDATA_WIDTH)) u_mac (
    .clk   (axis_clk),
    .rst_n (axis_rst_n),
    .clr   (mac_clr),
    .en    (mac_en),
    .a     (mac_a),
    .b     (mac_b),
    .acc   (acc)
  );

endmodule
